// File: rtl/alu_fpu_pkg.sv
// Shared types for the RV32IF execute unit.
// Op codes, FSM states and small helpers.
package alu_fpu_pkg;

  typedef enum logic [4:0] {
    OP_ADD  = 5'h00,
    OP_SUB  = 5'h01,
    OP_AND  = 5'h02,
    OP_OR   = 5'h03,
    OP_XOR  = 5'h04,
    OP_SLL  = 5'h05,
    OP_SRL  = 5'h06,
    OP_SRA  = 5'h07,
    OP_SLT  = 5'h08,
    OP_SLTU = 5'h09,
    OP_FADD = 5'h10,
    OP_FSUB = 5'h11,
    OP_FMUL = 5'h12
  } alu_op_e;

  typedef enum logic {S_IDLE, S_FP} state_e;

  localparam int FPU_LAT_DEF = 3;

  function automatic int cnt_w(input int lat);
    return $clog2(lat + 1);
  endfunction

  function automatic logic is_fp_op(input logic [4:0] op);
    return op[4];
  endfunction

endpackage

// File: rtl/alu.sv
// Combinational RV32I integer ALU.
// Shift amounts use the low five bits of b.
module alu
  import alu_fpu_pkg::*;
(
  input  logic [4:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y
);
  always_comb begin
    unique case (op)
      OP_ADD:  y = a + b;
      OP_SUB:  y = a - b;
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_SLL:  y = a << b[4:0];
      OP_SRL:  y = a >> b[4:0];
      OP_SRA:  y = $unsigned($signed(a) >>> b[4:0]);
      OP_SLT:  y = {31'd0, $signed(a) < $signed(b)};
      OP_SLTU: y = {31'd0, a < b};
      default: y = 32'd0;
    endcase
  end
endmodule

// File: rtl/alu_fpu_ctrl.sv
// Issue/complete FSM for the execute unit.
// Tracks the FP latency counter and the output valid bit.
module alu_fpu_ctrl
  import alu_fpu_pkg::*;
#(
  parameter int FPU_LAT = FPU_LAT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic valid,
  input  logic is_fp,
  input  logic flush,
  input  logic out_ready,
  output logic ready,
  output logic accept,
  output logic load,
  output logic busy,
  output logic out_valid
);
  localparam int CW = cnt_w(FPU_LAT);

  state_e state;
  logic [CW-1:0] cnt;
  logic drain_ok, fp_done;

  assign drain_ok = !out_valid || out_ready;
  assign ready    = (state == S_IDLE) && drain_ok && !flush;
  assign accept   = valid && ready;
  assign fp_done  = (state == S_FP) && (cnt == '0) && drain_ok && !flush;
  assign load     = (accept && !is_fp) || fp_done;
  assign busy     = (state == S_FP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      out_valid <= 1'b0;
    end else if (flush) begin
      state     <= S_IDLE;
      cnt       <= '0;
      out_valid <= 1'b0;
    end else begin
      // a fresh load wins over the consume-side clear
      if (load) out_valid <= 1'b1;
      else if (out_ready) out_valid <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (accept && is_fp) begin
            state <= S_FP;
            cnt   <= CW'(FPU_LAT - 1);
          end
        end
        S_FP: begin
          if (cnt != '0) cnt <= cnt - CW'(1);
          else if (drain_ok) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: rtl/final_select_ALPU.sv
// Result mux between integer ALU and FPU.
// Selects the FPU result while an FP op completes.
module final_select_ALPU (
  input  logic        sel_fp,
  input  logic [31:0] alu_res,
  input  logic [31:0] fpu_res,
  output logic [31:0] result
);
  assign result = sel_fp ? fpu_res : alu_res;
endmodule

// File: rtl/fpu_top.sv
// Combinational single-precision FADD/FSUB/FMUL.
// Denormals flush to zero; rounding is nearest-even.
module fpu_top
  import alu_fpu_pkg::*;
(
  input  logic [4:0]  op,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  output logic [31:0] result
);
  // m holds the hidden bit at 26 and guard/round/sticky in [2:0]
  function automatic logic [31:0] pack(
    input logic s, input logic signed [9:0] e, input logic [26:0] m);
    logic [24:0] r;
    logic signed [9:0] ex;
    r  = {1'b0, m[26:3]} + 25'(m[2] & (m[1] | m[0] | m[3]));
    ex = e;
    if (r[24]) begin
      r  = r >> 1;
      ex = ex + 10'sd1;
    end
    if (!m[26] || ex <= 0) pack = {s, 31'd0};
    else if (ex >= 255) pack = {s, 8'hff, 23'd0};
    else pack = {s, ex[7:0], r[22:0]};
  endfunction

  function automatic logic [31:0] fadd(
    input logic [31:0] x, input logic [31:0] y);
    logic [31:0] a, b;
    logic [26:0] ma, mb, mbs, nm;
    logic [27:0] sum;
    logic [7:0] d;
    logic [4:0] lz;
    logic signed [9:0] e;
    if (x[30:0] >= y[30:0]) begin
      a = x; b = y;
    end else begin
      a = y; b = x;
    end
    ma = (a[30:23] == 8'd0) ? 27'd0 : {1'b1, a[22:0], 3'b0};
    mb = (b[30:23] == 8'd0) ? 27'd0 : {1'b1, b[22:0], 3'b0};
    d  = a[30:23] - b[30:23];
    if (d > 8'd26) mbs = 27'(mb != 27'd0);
    else mbs = (mb >> d) |
      27'((mb & ~(27'h7ffffff << d)) != 27'd0);
    sum = (a[31] == b[31]) ? {1'b0, ma} + {1'b0, mbs}
                           : {1'b0, ma} - {1'b0, mbs};
    e = $signed({2'b0, a[30:23]});
    lz = 5'd0;
    if (sum[27]) begin
      nm = sum[27:1] | 27'(sum[0]);
      e  = e + 10'sd1;
    end else begin
      for (int i = 0; i <= 26; i++)
        if (sum[i]) lz = 5'(26 - i);
      nm = sum[26:0] << lz;
      e  = e - $signed({5'b0, lz});
    end
    if (sum == 28'd0) fadd = 32'd0;
    else fadd = pack(a[31], e, nm);
  endfunction

  function automatic logic [31:0] fmul(
    input logic [31:0] x, input logic [31:0] y);
    logic [47:0] p;
    logic [26:0] nm;
    logic signed [9:0] e;
    logic s;
    s = x[31] ^ y[31];
    p = {24'd0, 1'b1, x[22:0]} * {24'd0, 1'b1, y[22:0]};
    e = $signed({2'b0, x[30:23]}) + $signed({2'b0, y[30:23]})
        - 10'sd127;
    if (p[47]) begin
      nm = {p[47:22], |p[21:0]};
      e  = e + 10'sd1;
    end else begin
      nm = {p[46:21], |p[20:0]};
    end
    if (x[30:23] == 8'd0 || y[30:23] == 8'd0) fmul = {s, 31'd0};
    else fmul = pack(s, e, nm);
  endfunction

  always_comb begin
    case (op)
      OP_FSUB: result = fadd(rs1, {~rs2[31], rs2[30:0]});
      OP_FMUL: result = fmul(rs1, rs2);
      default: result = fadd(rs1, rs2);
    endcase
  end
endmodule

// File: rtl/alu_fpu_pipe.sv
// Handshaked integer/FP execute unit for RV32IF.
// Integer ops finish in one cycle, FP ops in FPU_LAT.
module alu_fpu_pipe
  import alu_fpu_pkg::*;
#(
  parameter int FPU_LAT = FPU_LAT_DEF,
  parameter int TAG_W   = 5
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [4:0]       i_alu_op,
  input  logic [31:0]      i_operand_a,
  input  logic [31:0]      i_operand_b,
  input  logic [31:0]      i_rs1_f,
  input  logic [31:0]      i_rs2_f,
  input  logic [TAG_W-1:0] i_tag,
  input  logic             i_flush,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [31:0]      o_result,
  output logic [TAG_W-1:0] o_tag,
  output logic             o_is_fp,
  output logic             o_busy
);
  logic accept, load, busy, op_fp;
  logic [4:0] op_q;
  logic [31:0] fa_q, fb_q;
  logic [TAG_W-1:0] tag_q;
  logic [31:0] alu_res, fpu_res, sel_res;

  assign op_fp  = is_fp_op(i_alu_op);
  assign o_busy = busy;

  alu_fpu_ctrl #(.FPU_LAT(FPU_LAT)) u_ctrl (
    .clk       (i_clk),
    .rst_n     (i_rst_n),
    .valid     (i_valid),
    .is_fp     (op_fp),
    .flush     (i_flush),
    .out_ready (i_ready),
    .ready     (o_ready),
    .accept    (accept),
    .load      (load),
    .busy      (busy),
    .out_valid (o_valid)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      op_q  <= '0;
      fa_q  <= '0;
      fb_q  <= '0;
      tag_q <= '0;
    end else if (accept) begin
      op_q  <= i_alu_op;
      fa_q  <= i_rs1_f;
      fb_q  <= i_rs2_f;
      tag_q <= i_tag;
    end
  end

  // integer result retires on the accept edge, so the ALU sees the issue bus
  alu u_alu (
    .op (i_alu_op),
    .a  (i_operand_a),
    .b  (i_operand_b),
    .y  (alu_res)
  );

  fpu_top u_fpu (
    .op     (op_q),
    .rs1    (fa_q),
    .rs2    (fb_q),
    .result (fpu_res)
  );

  final_select_ALPU u_sel (
    .sel_fp  (busy),
    .alu_res (alu_res),
    .fpu_res (fpu_res),
    .result  (sel_res)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_result <= '0;
      o_tag    <= '0;
      o_is_fp  <= 1'b0;
    end else if (load && !i_flush) begin
      o_result <= sel_res;
      o_tag    <= busy ? tag_q : i_tag;
      o_is_fp  <= busy;
    end
  end
endmodule
